// File: rtl/cdb_arbiter.sv
// cdb_arbiter: Common Data Bus arbiter. One small FIFO per result source;
// a round-robin pointer picks one non-empty FIFO per cycle and the popped
// head is registered onto the CDB the following edge.
// Optional build macro CDB_FLAGS_EN: carry ICC/Y writeback fields per entry.

// Per-source result FIFO: power-of-two depth, registered occupancy count.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 37
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 5,
  parameter int VAL_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         in_src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]   in_src_tag,
  input  logic [NUM_SRC*VAL_W-1:0]   in_src_val,
  input  logic [NUM_SRC*4-1:0]       in_src_icc,
  input  logic [NUM_SRC-1:0]         in_src_icc_we,
  input  logic [NUM_SRC*VAL_W-1:0]   in_src_y,
  input  logic [NUM_SRC-1:0]         in_src_y_we,
  output logic [NUM_SRC-1:0]         out_src_ready,
  output logic                       out_CDB_broadcast,
  output logic [TAG_W-1:0]           out_CDB_tag,
  output logic [VAL_W-1:0]           out_CDB_val,
  output logic [$clog2(NUM_SRC)-1:0] out_CDB_src,
  output logic [3:0]                 out_ICC_flags,
  output logic                       out_ICC_we,
  output logic [VAL_W-1:0]           out_Y_val,
  output logic                       out_Y_we,
  output logic                       out_bad_tag
);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int TV    = TAG_W + VAL_W;
`ifdef CDB_FLAGS_EN
  localparam int ENT_W = TV + 4 + 1 + VAL_W + 1;
`else
  localparam int ENT_W = TV;
`endif

  logic [NUM_SRC-1:0][ENT_W-1:0] ent_in, ent_out;
  logic [NUM_SRC-1:0]            push, pop, empty, full, bad;
  logic [SRC_W-1:0]              rr_ptr, win;
  logic                          any;
  logic [ENT_W-1:0]              head;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign out_src_ready[i] = !rst && !full[i];
    assign bad[i]  = in_src_valid[i] && out_src_ready[i] &&
                     (in_src_tag[i*TAG_W +: TAG_W] == '1);
    assign push[i] = in_src_valid[i] && out_src_ready[i] && !bad[i];
`ifdef CDB_FLAGS_EN
    assign ent_in[i] = {in_src_y_we[i], in_src_y[i*VAL_W +: VAL_W],
                        in_src_icc_we[i], in_src_icc[i*4 +: 4],
                        in_src_tag[i*TAG_W +: TAG_W], in_src_val[i*VAL_W +: VAL_W]};
`else
    assign ent_in[i] = {in_src_tag[i*TAG_W +: TAG_W], in_src_val[i*VAL_W +: VAL_W]};
`endif

    cdb_src_fifo #(.DEPTH(FIFO_DEPTH), .DW(ENT_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   (ent_in[i]),
      .pop   (pop[i]),
      .dout  (ent_out[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

`ifndef CDB_FLAGS_EN
  // Flag inputs have no destination in this build.
  logic unused_flags;
  assign unused_flags = ^{in_src_icc, in_src_icc_we, in_src_y, in_src_y_we};
`endif

  // Round-robin pick: first non-empty FIFO at or after rr_ptr, with wrap.
  always_comb begin
    any = 1'b0;
    win = '0;
    pop = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!any && !empty[(int'(rr_ptr) + k) % NUM_SRC]) begin
        any = 1'b1;
        win = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
    if (any) pop[win] = 1'b1;
  end

  assign head = ent_out[win];

  // Register the granted head onto the CDB; fields hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr            <= '0;
      out_CDB_broadcast <= 1'b0;
      out_CDB_tag       <= '0;
      out_CDB_val       <= '0;
      out_CDB_src       <= '0;
    end else begin
      out_CDB_broadcast <= any;
      if (any) begin
        out_CDB_val <= head[VAL_W-1:0];
        out_CDB_tag <= head[VAL_W +: TAG_W];
        out_CDB_src <= win;
        rr_ptr      <= (int'(win) == NUM_SRC - 1) ? '0 : win + 1'b1;
      end
    end
  end

  // Sticky flag for an INVALID_TAG handshake; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)       out_bad_tag <= 1'b0;
    else if (|bad) out_bad_tag <= 1'b1;
  end

`ifdef CDB_FLAGS_EN
  // ICC/Y writeback fields; enables are qualified by the broadcast.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ICC_flags <= '0;
      out_ICC_we    <= 1'b0;
      out_Y_val     <= '0;
      out_Y_we      <= 1'b0;
    end else begin
      out_ICC_we <= any && head[TV+4];
      out_Y_we   <= any && head[TV+5+VAL_W];
      if (any) begin
        out_ICC_flags <= head[TV +: 4];
        out_Y_val     <= head[TV+5 +: VAL_W];
      end
    end
  end
`else
  assign out_ICC_flags = '0;
  assign out_ICC_we    = 1'b0;
  assign out_Y_val     = '0;
  assign out_Y_we      = 1'b0;
`endif
endmodule
